adc_frame_aligner: RTL and testbench



---
 rtl/adc_frame_aligner.sv | 151 +++++++++++++++
 tb/tb_adc_frame_aligner.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/adc_frame_aligner.sv
// adc_frame_aligner: bitslip-driven frame search and lock monitor for LVDS ADC SERDES words,
// with per-channel sample unpacking and output format conversion.
module adc_frame_aligner #(
    parameter int                      NUM_CH         = 2,
    parameter int                      LANES_PER_CH   = 2,
    parameter int                      SERDES_RATIO   = 7,
    parameter int                      OUT_BITS       = 16,
    parameter logic [SERDES_RATIO-1:0] FRAME_PATTERN  = '0,
    parameter bit                      ACCEPT_INVERSE = 1'b1,
    parameter int                      FORMAT         = 0,
    parameter int                      BITSLIP_GAP    = 4,
    parameter int                      LOCK_COUNT     = 8,
    parameter int                      LOSS_COUNT     = 2,
    parameter int                      MAX_SLIPS      = 14
) (
    input  logic                                           clk,
    input  logic                                           reset,
    input  logic [(NUM_CH*LANES_PER_CH+1)*SERDES_RATIO-1:0] serdes_data,
    input  logic                                           realign,
    output logic                                           bitslip,
    output logic [NUM_CH*OUT_BITS-1:0]                     data_out,
    output logic                                           data_valid,
    output logic                                           locked,
    output logic                                           align_fail,
    output logic [7:0]                                     slip_count,
    output logic [15:0]                                    err_count
);
    localparam int NL = NUM_CH*LANES_PER_CH+1;
    localparam int SB = LANES_PER_CH*SERDES_RATIO;
    localparam logic [15:0] LOCK_N   = 16'(LOCK_COUNT);
    localparam logic [15:0] LOSS_N   = 16'(LOSS_COUNT);
    localparam logic [15:0] GAP_LAST = 16'(BITSLIP_GAP-1);
    localparam logic [7:0]  SLIP_MAX = 8'(MAX_SLIPS);
    localparam logic [SB-1:0] SIGN_FLIP = (FORMAT == 2) ? (SB'(1) << (SB-1)) : '0;

    typedef enum logic [2:0] {SEARCH, SLIP_WAIT, VERIFY, LOCKED, FAIL} state_t;

    state_t                         r_state;
    logic [NL*SERDES_RATIO-1:0]     r_din;
    logic [15:0]                    r_cnt;
    logic [15:0]                    r_miss;
    logic [15:0]                    r_gap;
    logic [SERDES_RATIO-1:0]        w_frame;
    logic [SB-1:0]                  w_raw [NUM_CH];
    logic [NUM_CH*OUT_BITS-1:0]     w_conv;
    logic                           w_match;

    always_comb begin
        w_frame = '0;
        w_conv  = '0;
        for (int c = 0; c < NUM_CH; c++) w_raw[c] = '0;
        for (int k = 0; k < SERDES_RATIO; k++) begin
            w_frame[SERDES_RATIO-1-k] = r_din[k*NL+NL-1];
            for (int c = 0; c < NUM_CH; c++)
                for (int l = 0; l < LANES_PER_CH; l++)
                    w_raw[c][SB-1-l*SERDES_RATIO-k] = r_din[k*NL+c*LANES_PER_CH+l];
        end
        // offset binary becomes two's complement by flipping the MSB before sign extension
        for (int c = 0; c < NUM_CH; c++)
            w_conv[c*OUT_BITS +: OUT_BITS] = (FORMAT == 0) ? OUT_BITS'(w_raw[c])
                                                           : OUT_BITS'(signed'(w_raw[c] ^ SIGN_FLIP));
        w_match = (w_frame == FRAME_PATTERN) || (ACCEPT_INVERSE && (w_frame == ~FRAME_PATTERN));
    end

    always_ff @(posedge clk) begin
        r_din <= serdes_data;
        if (reset) begin
            r_state    <= SEARCH;
            r_cnt      <= '0;
            r_miss     <= '0;
            r_gap      <= '0;
            bitslip    <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            locked     <= 1'b0;
            align_fail <= 1'b0;
            slip_count <= '0;
            err_count  <= '0;
        end else begin
            bitslip    <= 1'b0;
            data_out   <= w_conv;
            data_valid <= 1'b0;
            if (realign) begin
                r_state    <= SEARCH;
                r_cnt      <= '0;
                r_miss     <= '0;
                r_gap      <= '0;
                slip_count <= '0;
                locked     <= 1'b0;
                align_fail <= 1'b0;
            end else begin
                case (r_state)
                    SEARCH: begin
                        if (w_match) begin
                            r_cnt <= 16'd1;
                            if (LOCK_N == 16'd1) begin
                                r_state    <= LOCKED;
                                locked     <= 1'b1;
                                data_valid <= 1'b1;
                            end else begin
                                r_state <= VERIFY;
                            end
                        end else if (slip_count < SLIP_MAX) begin
                            r_state    <= SLIP_WAIT;
                            r_gap      <= '0;
                            bitslip    <= 1'b1;
                            slip_count <= slip_count + 8'd1;
                        end else begin
                            r_state    <= FAIL;
                            align_fail <= 1'b1;
                        end
                    end
                    SLIP_WAIT: begin
                        r_gap <= r_gap + 16'd1;
                        if (r_gap == GAP_LAST) r_state <= SEARCH;
                    end
                    VERIFY: begin
                        if (w_match) begin
                            r_cnt <= r_cnt + 16'd1;
                            if (r_cnt + 16'd1 == LOCK_N) begin
                                r_state    <= LOCKED;
                                locked     <= 1'b1;
                                data_valid <= 1'b1;
                            end
                        end else begin
                            r_state <= SEARCH;
                            r_cnt   <= '0;
                        end
                    end
                    LOCKED: begin
                        if (w_match) begin
                            r_miss     <= '0;
                            data_valid <= 1'b1;
                        end else begin
                            err_count <= err_count + {15'd0, err_count != 16'hFFFF};
                            r_miss    <= r_miss + 16'd1;
                            if (r_miss + 16'd1 == LOSS_N) begin
                                r_state    <= SEARCH;
                                r_miss     <= '0;
                                r_cnt      <= '0;
                                slip_count <= '0;
                                locked     <= 1'b0;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_adc_frame_aligner.sv
// tb_adc_frame_aligner: directed vector table plus hand-written lock/loss/fail/rotation sequences.
module tb_adc_frame_aligner;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rst_r, realign;
    logic [34:0] din, din_r;
    logic [39:0] din_d;
    int          rot;

    logic        bs_a, dv_a, lk_a, af_a; logic [31:0] do_a; logic [7:0] sc_a; logic [15:0] ec_a;
    logic        bs_b, dv_b, lk_b, af_b; logic [31:0] do_b; logic [7:0] sc_b; logic [15:0] ec_b;
    logic        bs_c, dv_c, lk_c, af_c; logic [31:0] do_c; logic [7:0] sc_c; logic [15:0] ec_c;
    logic        bs_r, dv_r, lk_r, af_r; logic [31:0] do_r; logic [7:0] sc_r; logic [15:0] ec_r;
    logic        bs_d, dv_d, lk_d, af_d; logic [31:0] do_d; logic [7:0] sc_d; logic [15:0] ec_d;

    adc_frame_aligner u_a (.clk(clk), .reset(rst), .serdes_data(din), .realign(realign), .bitslip(bs_a),
        .data_out(do_a), .data_valid(dv_a), .locked(lk_a), .align_fail(af_a), .slip_count(sc_a), .err_count(ec_a));
    adc_frame_aligner #(.FORMAT(2)) u_b (.clk(clk), .reset(rst), .serdes_data(din), .realign(realign), .bitslip(bs_b),
        .data_out(do_b), .data_valid(dv_b), .locked(lk_b), .align_fail(af_b), .slip_count(sc_b), .err_count(ec_b));
    adc_frame_aligner #(.FORMAT(1)) u_c (.clk(clk), .reset(rst), .serdes_data(din), .realign(realign), .bitslip(bs_c),
        .data_out(do_c), .data_valid(dv_c), .locked(lk_c), .align_fail(af_c), .slip_count(sc_c), .err_count(ec_c));
    adc_frame_aligner #(.FRAME_PATTERN(7'b1111000), .ACCEPT_INVERSE(1'b0)) u_r (.clk(clk), .reset(rst_r),
        .serdes_data(din_r), .realign(1'b0), .bitslip(bs_r), .data_out(do_r), .data_valid(dv_r), .locked(lk_r),
        .align_fail(af_r), .slip_count(sc_r), .err_count(ec_r));
    adc_frame_aligner #(.NUM_CH(4), .LANES_PER_CH(1), .SERDES_RATIO(8), .OUT_BITS(8), .FRAME_PATTERN(8'hFF),
        .ACCEPT_INVERSE(1'b1)) u_d (.clk(clk), .reset(rst), .serdes_data(din_d), .realign(1'b0), .bitslip(bs_d),
        .data_out(do_d), .data_valid(dv_d), .locked(lk_d), .align_fail(af_d), .slip_count(sc_d), .err_count(ec_d));

    function automatic logic [34:0] mk(input logic [6:0] f, input logic [13:0] r0, input logic [13:0] r1);
        logic [34:0] w = '0;
        for (int k = 0; k < 7; k++) begin
            w[k*5+4] = f[6-k];
            w[k*5+0] = r0[13-k];
            w[k*5+1] = r0[6-k];
            w[k*5+2] = r1[13-k];
            w[k*5+3] = r1[6-k];
        end
        return w;
    endfunction

    function automatic logic [39:0] mk4(input logic [7:0] f, input logic [31:0] s);
        logic [39:0] w = '0;
        for (int k = 0; k < 8; k++) begin
            w[k*5+4] = f[7-k];
            for (int c = 0; c < 4; c++) w[k*5+c] = s[c*8+7-k];
        end
        return w;
    endfunction

    function automatic logic [6:0] rotf(input int r);
        logic [6:0] p = 7'b1111000;
        logic [6:0] f = '0;
        for (int i = 0; i < 7; i++) f[i] = p[(i+r)%7];
        return f;
    endfunction

    // SERDES model: each bitslip pulse rotates the received frame lane by one bit
    always @(posedge clk) begin
        if (rst_r) rot <= 4;
        else if (bs_r) rot <= (rot + 1) % 7;
    end
    assign din_r = mk(rotf(rot), 14'h0, 14'h0);

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [6:0]  f;
        logic [13:0] r0;
        logic [13:0] r1;
        logic [31:0] ea;
        logic [31:0] eb;
        logic [31:0] ec;
    } vec_t;
    vec_t tbl [5];

    initial begin
        int n, cyc, last;
        bit bad;
        logic [31:0] prev;
        tbl[0] = '{7'h00, 14'h1234, 14'h0000, 32'h0000_1234, 32'hE000_F234, 32'h0000_1234};
        tbl[1] = '{7'h00, 14'h3FFF, 14'h2000, 32'h2000_3FFF, 32'h0000_1FFF, 32'hE000_FFFF};
        tbl[2] = '{7'h7F, 14'h0000, 14'h3FFF, 32'h3FFF_0000, 32'h1FFF_E000, 32'hFFFF_0000};
        tbl[3] = '{7'h00, 14'h2000, 14'h0ABC, 32'h0ABC_2000, 32'hEABC_0000, 32'h0ABC_E000};
        tbl[4] = '{7'h7F, 14'h0ABC, 14'h1234, 32'h1234_0ABC, 32'hF234_EABC, 32'h1234_0ABC};
        rst = 1'b1; rst_r = 1'b1; realign = 1'b0;
        din   = mk(7'h00, 14'h0, 14'h0);
        din_d = mk4(8'hFF, 32'h7E81_3CA5);
        repeat (3) @(negedge clk);
        chk("rst_bitslip", bs_a, 0);
        chk("rst_data", do_a, 0);
        chk("rst_valid", dv_a, 0);
        chk("rst_locked", lk_a, 0);
        chk("rst_fail", af_a, 0);
        chk("rst_slips", sc_a, 0);
        chk("rst_errs", ec_a, 0);
        rst = 1'b0;
        n = 0;
        repeat (7) begin @(negedge clk); n += bs_a; end
        chk("lock_early", lk_a, 0);
        chk("valid_early", dv_a, 0);
        @(negedge clk);
        chk("lock_time", lk_a, 1);
        chk("valid_with_lock", dv_a, 1);
        chk("no_bitslip", n, 0);
        chk("d_locked", lk_d, 1);
        chk("d_data", do_d, 32'h7E81_3CA5);
        din_d = mk4(8'h00, 32'h8004_0201);
        repeat (2) @(negedge clk);
        chk("d_inverse_valid", dv_d, 1);
        chk("d_inverse_data", do_d, 32'h8004_0201);

        prev = 32'h0;
        for (int i = 0; i < 5; i++) begin
            din = mk(tbl[i].f, tbl[i].r0, tbl[i].r1);
            @(negedge clk);
            chk($sformatf("latency_a%0d", i), do_a, prev);
            @(negedge clk);
            chk($sformatf("fmt0_a%0d", i), do_a, tbl[i].ea);
            chk($sformatf("fmt2_b%0d", i), do_b, tbl[i].eb);
            chk($sformatf("fmt1_c%0d", i), do_c, tbl[i].ec);
            chk($sformatf("valid_a%0d", i), dv_a, 1);
            prev = tbl[i].ea;
        end

        din = mk(7'b0101010, 14'h0, 14'h0);
        @(negedge clk);
        din = mk(7'h00, 14'h0, 14'h0);
        @(negedge clk);
        chk("glitch_valid", dv_a, 0);
        chk("glitch_locked", lk_a, 1);
        chk("glitch_errs", ec_a, 1);
        @(negedge clk);
        chk("glitch_recover", dv_a, 1);
        din = mk(7'b0101010, 14'h0, 14'h0);
        repeat (2) @(negedge clk);
        din = mk(7'h00, 14'h0, 14'h0);
        @(negedge clk);
        chk("loss_locked", lk_a, 0);
        chk("loss_valid", dv_a, 0);
        chk("loss_errs", ec_a, 3);
        chk("loss_slips", sc_a, 0);
        cyc = 0;
        while (!lk_a && cyc < 20) begin @(negedge clk); cyc++; end
        chk("relock_cycles", cyc, 8);
        chk("relock_errs", ec_a, 3);

        n = 0; cyc = 0;
        while (!af_a && cyc < 200) begin
            din = mk((cyc % 2 == 1) ? 7'b1010101 : 7'b0101010, 14'h0, 14'h0);
            @(negedge clk);
            n += bs_a;
            cyc++;
        end
        chk("fail_flag", af_a, 1);
        chk("fail_pulses", n, 14);
        chk("fail_slips", sc_a, 14);
        chk("fail_errs", ec_a, 5);
        n = 0;
        repeat (10) begin
            din = mk((cyc % 2 == 1) ? 7'b1010101 : 7'b0101010, 14'h0, 14'h0);
            @(negedge clk);
            n += bs_a;
            cyc++;
        end
        chk("fail_quiet", n, 0);
        chk("fail_hold", af_a, 1);
        realign = 1'b1;
        @(negedge clk);
        realign = 1'b0;
        chk("realign_slips", sc_a, 0);
        chk("realign_fail", af_a, 0);
        chk("realign_errs", ec_a, 5);
        @(negedge clk);
        chk("realign_slip_pulse", bs_a, 1);
        chk("realign_slips_next", sc_a, 1);

        rst_r = 1'b0;
        n = 0; cyc = 0; last = 0; bad = 1'b0;
        while (!lk_r && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (bs_r) begin
                if (n > 0 && cyc - last != 5) bad = 1'b1;
                last = cyc;
                n++;
            end
        end
        chk("rot_pulses", n, 3);
        chk("rot_spacing_bad", bad, 0);
        chk("rot_slips", sc_r, 3);
        chk("rot_locked", lk_r, 1);
        chk("rot_valid", dv_r, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
